// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared types and constants for the spi_target SPI responder.
//   state_e      transaction state (IDLE, CMD, WDATA, RDATA)
//   CMD_RW_BIT   bit of the command byte selecting write (1) or read (0)
//   SYNC_STAGES  depth of the bus synchronisers
package spi_target_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_e;

    localparam int unsigned CMD_RW_BIT  = 7;
    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/spi_target_sync.sv
// spi_target_sync: multi-flop synchroniser with edge detection for one
// asynchronous bus line. All flops reset to RESET_VAL (the idle bus level),
// so no spurious edge is reported on leaving reset.
// Ports:
//   clk_i   local clock
//   rst_i   synchronous active-high reset
//   d_i     asynchronous input
//   q_o     synchronised level (last synchroniser stage)
//   rise_o  one-cycle pulse on a synchronised 0->1 transition
//   fall_o  one-cycle pulse on a synchronised 1->0 transition
module spi_target_sync
    import spi_target_pkg::*;
#(
    parameter int unsigned STAGES    = SYNC_STAGES,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder (MSB first) bridging a command byte plus a
// data burst onto a local register bus with one-cycle read/write strobes.
// The first byte shifted out is always status_in; read data follows.
// Ports:
//   clk, cpld_rst              local clock, synchronous active-high reset
//   SPI_csb, SPI_sck, SPI_si   bus inputs, asynchronous to clk
//   SPI_so, so_oe              serial data out and its output enable
//   status_in                  status byte returned first in every transaction
//   reg_addr, reg_wdata        register bus address and write data
//   reg_we, reg_re             one-cycle write / read strobes
//   reg_rdata                  read data, valid the cycle after reg_re
//   busy                       transaction open
// Build option: define SPI_TARGET_AUTOINC_EN to advance the address by one
// after each data byte; otherwise the command address is held (FIFO port).
module spi_target
    import spi_target_pkg::*;
#(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              cpld_rst,
    input  logic              SPI_csb,
    input  logic              SPI_sck,
    input  logic              SPI_si,
    output logic              SPI_so,
    output logic              so_oe,
    input  logic [7:0]        status_in,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

`ifdef SPI_TARGET_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    // ---------------- bus synchronisers ----------------
    logic csb_s, csb_rise, csb_fall;
    logic sck_s, sck_rise, sck_fall;
    logic si_s, si_rise, si_fall;
    logic [1:0] si_unused;

    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
        .clk_i(clk), .rst_i(cpld_rst), .d_i(SPI_csb),
        .q_o(csb_s), .rise_o(csb_rise), .fall_o(csb_fall)
    );
    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk_i(clk), .rst_i(cpld_rst), .d_i(SPI_sck),
        .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_si (
        .clk_i(clk), .rst_i(cpld_rst), .d_i(SPI_si),
        .q_o(si_s), .rise_o(si_rise), .fall_o(si_fall)
    );
    assign si_unused = {si_rise, si_fall};

    // ---------------- state and datapath registers ----------------
    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q;
    logic [6:0]        rx_q;
    logic [7:0]        tx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              load_q;
    logic [SYNC_STAGES:0] fill_q;
    logic              armed_q;

    logic       active;
    logic       bit_rise;
    logic       byte_done;
    logic       start;
    logic [7:0] rx_byte;

    // The synchronisers reset to the idle bus, so a reset taken while csb is
    // really low looks like a fresh csb fall once they refill. armed_q stays
    // low until a genuinely high csb has been seen after the synchronisers
    // have refilled, so that phantom fall and the rest of the interrupted
    // transaction are ignored.
    assign active    = (state_q != IDLE);
    assign bit_rise  = sck_rise && active;
    assign rx_byte   = {rx_q, si_s};
    assign byte_done = bit_rise && (bit_cnt_q == 3'd7);
    assign start     = (state_q == IDLE) && csb_fall && armed_q;

    // State register
    always_ff @(posedge clk) begin
        if (cpld_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a csb rise wins over any other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CMD;
            CMD:     if (byte_done) state_d = rx_byte[CMD_RW_BIT] ? WDATA : RDATA;
            default: state_d = state_q;
        endcase
        if (csb_rise) state_d = IDLE;
    end

    // Strobe logic; a completed byte still strobes when csb rises in the same cycle
    always_comb begin
        we_d = 1'b0;
        re_d = 1'b0;
        if (byte_done) begin
            case (state_q)
                CMD:     re_d = !rx_byte[CMD_RW_BIT];
                WDATA:   we_d = 1'b1;
                RDATA:   re_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cpld_rst) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            load_q    <= 1'b0;
            fill_q    <= '0;
            armed_q   <= 1'b0;
        end else begin
            we_q   <= we_d;
            re_q   <= re_d;
            load_q <= re_q;
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            armed_q <= armed_q | (fill_q[SYNC_STAGES] & csb_s & ~csb_rise);

            if (start || csb_rise) begin
                bit_cnt_q <= '0;
            end else if (bit_rise) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if (bit_rise) begin
                rx_q <= rx_byte[6:0];
            end

            // No shift on the fall right after a byte boundary, so a freshly
            // loaded byte presents its MSB for the next rise.
            if (start) begin
                tx_q <= status_in;
            end else if (load_q && (state_q == RDATA)) begin
                tx_q <= reg_rdata;
            end else if (sck_fall && active && (bit_cnt_q != 3'd0)) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end

            if (byte_done && (state_q == CMD)) begin
                addr_q <= rx_byte[ADDR_W-1:0];
            end else if (AUTOINC && ((byte_done && (state_q == RDATA)) || we_q)) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            if (we_d) begin
                wdata_q <= rx_byte;
            end
        end
    end

    assign SPI_so    = tx_q[7];
    assign so_oe     = armed_q & ~csb_s;
    assign busy      = armed_q & ~csb_s;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;

endmodule

// File: doc/spi_target.md
# spi_target

SPI responder (mode 0, MSB first) for an expansion board on the badge SPI bus: the board's controller is the initiator, and this block is the far end. It deserialises a command byte plus a data burst into single-cycle strobes on a local register bus, and serialises register read data back on SO. It runs on the local clock and oversamples the bus through synchronisers.

## Interface
Parameters:
- ADDR_W, 7: register address width; the command byte carries {rw, addr[6:0]}.

Ports:
- clk  in  1  local clock. SCK must be at most clk/8 (each SCK half-period ≥ 4 clk).
- cpld_rst  in  1  reset. One clock; reset is synchronous and active-high.
- SPI_csb  in  1  chip select, active low, asynchronous to clk.
- SPI_sck  in  1  serial clock; idles low.
- SPI_si  in  1  data from the initiator.
- SPI_so  out  1  data to the initiator; valid only while so_oe is high.
- so_oe  out  1  SO output enable: the synchronised csb is low.
- status_in  in  8  first byte returned in every transaction.
- reg_addr  out  ADDR_W  register bus address.
- reg_wdata  out  8  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data, valid the cycle after reg_re.
- busy  out  1  high while a transaction is open (synchronised csb low).

## Operation
- Synchronisation:
  - csb, sck and si each pass through 2 flops.
  - Edges are detected between sync stage 2 and a third flop.
  - si is taken from the same stage as sck, so bit samples stay aligned.
- bit_cnt is 3 bits. It increments on each detected SCK rise while CSB is low.
- rx_shift takes si on each rise. A byte completes on the rise where bit_cnt==7.
- tx_shift drives SPI_so = tx_shift[7].
  - On a detected SCK fall it shifts left only if bit_cnt != 0.
  - The fall after a byte boundary therefore presents the already-loaded next MSB.
- State machine:
  - IDLE: on detected csb fall, load tx_shift with status_in, clear bit_cnt, go to CMD.
  - CMD: on byte completion, latch reg_addr = rx[ADDR_W-1:0].
    - If rx[7]=1, go to WDATA.
    - Otherwise go to RDATA and pulse reg_re the next cycle.
  - WDATA: on each byte completion, set reg_wdata = rx, pulse reg_we one cycle, then advance the address.
  - RDATA:
    - The cycle after reg_re, load tx_shift from reg_rdata.
    - On each byte completion, advance the address and pulse reg_re again (prefetch).
  - Any state: a detected csb rise returns to IDLE, clears bit_cnt and drops so_oe.
- The address advances by +1 mod 2^ADDR_W when the autoincrement feature is compiled in (see Configuration).
- The initiator receives, in order: the status byte, then in a read transaction mem[a], mem[a+1], and so on.

## Timing
- Reset values: SPI_so=0, so_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0; state IDLE, bit_cnt=0, shift registers 0.
- The sync stages reset to the idle bus: csb=1, sck=0.
- Reset mid-transaction: return to IDLE, emit no strobe, ignore bus activity until the next csb fall.
- Latency:
  - Bus edge to detection: 3 clk.
  - Byte completion to reg_we: 1 clk.
  - Byte completion to reg_re: 1 clk; tx_shift loads 1 clk after reg_re.
  - The load always lands before the next detected fall, given the ≥4-clk half-period.
- CSB rise with bit_cnt != 0 aborts the transaction:
  - The partial byte is discarded and no reg_we is issued.
  - A prefetch reg_re issued after the last full read byte is legal and harmless; reg_re has no side effects by contract.
- CSB rise and byte completion detected in the same cycle: the completion is honoured first (its strobe fires), then the block enters IDLE.
- A CSB fall while not in IDLE cannot occur; synchronised csb is monotonic between edges.
- A burst past the top address wraps to address 0.

## Configuration
- SPI_TARGET_AUTOINC_EN:
  - Defined: the address advances by 1 after each data byte, for burst access.
  - Undefined: reg_addr holds the command address for the whole transaction (FIFO-style port). reg_we and reg_re still pulse once per byte.

## Structure
- Package spi_target_pkg holds:
  - the state enum (IDLE, CMD, WDATA, RDATA);
  - CMD_RW_BIT = 7;
  - SYNC_STAGES = 2.
- Sub-module spi_target_sync: a reset-to-value multi-flop synchroniser plus edge detector, instantiated for csb, sck and si.

## Test plan
- Write burst: CSB low; send 0x85, 0x11, 0x22; CSB high.
  - Expect reg_we at addresses 0x05 and 0x06 with data 0x11 and 0x22.
  - Expect the initiator to read back status_in=0xA5 during the command byte.
- Read burst: model returns mem[a]=a^0xFF; send 0x10 then two dummy bytes.
  - Expect SO bytes 0xA5 (status), 0xEF, 0xEE.
  - Expect reg_re at 0x10, 0x11 and a prefetch at 0x12.
- Abort: send 0x83 then 4 bits of data and raise CSB.
  - Expect no reg_we, so_oe=0 within 3 clk, and state IDLE.
  - The next transaction behaves normally.
- Reset: assert cpld_rst during the 2nd data bit of a write.
  - Expect all outputs to reach their reset values the next clk and no strobe.
- Wrap and config:
  - With the macro defined, a write at 0xFF plus 2 data bytes hits addresses 0x7F then 0x00.
  - Without the macro, both bytes hit 0x7F.
